// File: rtl/lp_mult_pkg.sv
// Shared types and defaults for the low-power iterative multiplier.
// Holds the FSM state encoding and the default operand width.
package lp_mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_sign_mag.sv
// Combinational sign/magnitude helper: passes x through, or returns its
// two's-complement negation when neg_i is set (|x| for operands, -r for results).
module mult_sign_mag #(
  parameter int N = 8
) (
  input  logic [N-1:0] x_i,
  input  logic         neg_i,
  output logic [N-1:0] y_o
);

  // Negating the most-negative value wraps back to the same bit pattern,
  // which read as unsigned is exactly its magnitude 2^(N-1).
  assign y_o = neg_i ? (~x_i + N'(1)) : x_i;

endmodule

// File: rtl/seq_mult_lp.sv
// Iterative shift-add multiplier with valid/ready handshakes, signed/unsigned
// mode, optional early termination and enable-gated datapath registers.
module seq_mult_lp
  import lp_mult_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready
  // are both high. in_ready is high only in IDLE; out_valid only in DONE and,
  // once raised, stays high with a stable product until out_ready is seen.

  state_e            state_q, state_d;
  logic [PW-1:0]     mcand_q;
  logic [WIDTH-1:0]  mplr_q;
  logic [PW-1:0]     acc_q;
  logic [CW-1:0]     count_q;
  logic              neg_q;
  logic [PW-1:0]     product_q;

  logic              accept;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [PW-1:0]     acc_sum, acc_next, result;
  logic [WIDTH-1:0]  mplr_shift;
  logic              last_iter;
  logic              in_calc;

  mult_sign_mag #(.N(WIDTH)) u_abs_a (
    .x_i   (a),
    .neg_i (signed_mode & a[WIDTH-1]),
    .y_o   (a_mag)
  );

  mult_sign_mag #(.N(WIDTH)) u_abs_b (
    .x_i   (b),
    .neg_i (signed_mode & b[WIDTH-1]),
    .y_o   (b_mag)
  );

  mult_sign_mag #(.N(PW)) u_res_neg (
    .x_i   (acc_next),
    .neg_i (neg_q),
    .y_o   (result)
  );

  assign accept     = in_valid && in_ready;
  assign in_calc    = (state_q == CALC);
  assign acc_sum    = acc_q + mcand_q;
  assign acc_next   = mplr_q[0] ? acc_sum : acc_q;
  assign mplr_shift = mplr_q >> 1;
  assign last_iter  = (count_q == LAST_COUNT) ||
                      (EARLY_TERM && (mplr_shift == '0));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand and product registers load only on a handshake or final
  // iteration; the accumulator only when the current multiplier bit is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      if (accept) begin
        mcand_q <= {{WIDTH{1'b0}}, a_mag};
        mplr_q  <= b_mag;
        neg_q   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        count_q <= '0;
      end else if (in_calc) begin
        mcand_q <= mcand_q << 1;
        mplr_q  <= mplr_shift;
        count_q <= count_q + CW'(1);
      end
      if (accept) begin
        acc_q <= '0;
      end else if (in_calc && mplr_q[0]) begin
        acc_q <= acc_sum;
      end
      if (in_calc && last_iter) begin
        product_q <= result;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_mult_lp.sv
// Directed bench for seq_mult_lp: one early-terminating instance and one
// fixed-latency instance, checked against hand-computed products and latencies.
module tb_seq_mult_lp;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           signed_mode;
  logic [W-1:0]   a, b;

  logic           in_valid, out_ready, in_ready, out_valid, busy;
  logic [2*W-1:0] product;

  logic           f_in_valid, f_out_ready, f_in_ready, f_out_valid, f_busy;
  logic [2*W-1:0] f_product;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];

  seq_mult_lp #(.WIDTH(W), .EARLY_TERM(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .busy        (busy)
  );

  seq_mult_lp #(.WIDTH(W), .EARLY_TERM(1'b0)) dut_ft (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (f_in_valid),
    .in_ready    (f_in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (f_out_valid),
    .out_ready   (f_out_ready),
    .product     (f_product),
    .busy        (f_busy)
  );

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver ----------------
  // sel=0 drives the early-terminating instance, sel=1 the fixed-latency one.
  // Latency is counted in rising edges from the accept edge (inclusive) to the
  // first edge after which out_valid is high, i.e. N+1.
  task automatic run_txn(input bit sel, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tsm, input logic [2*W-1:0] texp, input int tn,
                         input bit release_out, input string tag);
    logic [2*W-1:0] e;
    int lat;
    @(negedge clk);
    a = ta;
    b = tb;
    signed_mode = tsm;
    if (sel) f_in_valid = 1'b1;
    else     in_valid   = 1'b1;
    exp_q.push_back(texp);
    chk({tag, "_in_ready"}, sel ? f_in_ready : in_ready, 1);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    f_in_valid = 1'b0;
    lat = 1;
    while (!(sel ? f_out_valid : out_valid) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = exp_q.pop_front();
    chk({tag, "_latency"}, lat, tn + 1);
    chk({tag, "_product"}, sel ? f_product : product, e);
    chk({tag, "_busy"}, sel ? f_busy : busy, 1);
    if (release_out) begin
      @(negedge clk);
      if (sel) f_out_ready = 1'b1;
      else     out_ready   = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_valid_drop"}, sel ? f_out_valid : out_valid, 0);
      chk({tag, "_idle"}, sel ? f_in_ready : in_ready, 1);
      out_ready   = 1'b0;
      f_out_ready = 1'b0;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    f_in_valid = 1'b0;
    f_out_ready = 1'b0;
    signed_mode = 1'b0;
    a = '0;
    b = '0;

    #1;
    chk("rst_product", product, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_txn(0, 8'd13, 8'd11, 1'b0, 16'h008F, 4, 1, "u13x11");
    run_txn(0, 8'hFD, 8'h05, 1'b1, 16'hFFF1, 3, 1, "s_m3x5");
    run_txn(0, 8'h80, 8'h80, 1'b1, 16'h4000, 8, 1, "s_m128sq");
    run_txn(0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 8, 1, "u255sq");
    run_txn(0, 8'hFF, 8'hFF, 1'b1, 16'h0001, 1, 1, "s_m1sq");
    run_txn(0, 8'h7F, 8'h80, 1'b1, 16'hC080, 8, 1, "s_127xm128");
    run_txn(0, 8'hA5, 8'h00, 1'b0, 16'h0000, 1, 1, "u_b0");
    run_txn(1, 8'hA5, 8'h00, 1'b0, 16'h0000, 8, 1, "ft_b0");
    run_txn(1, 8'd13, 8'd11, 1'b0, 16'h008F, 8, 1, "ft13x11");

    // Backpressure: hold the result, poke in_valid, confirm nothing is taken.
    run_txn(0, 8'h0C, 8'h03, 1'b0, 16'h0024, 2, 0, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        a = 8'd2;
        b = 8'd2;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_product", product, 16'h0024);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_idle", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_accept_valid", out_valid, 0);
    chk("bp_no_accept_busy", busy, 0);
    chk("bp_product_held", product, 16'h0024);

    // Reset in the middle of 0xFF*0xFF after two iterations.
    @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_busy_before_rst", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_product", product, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    run_txn(0, 8'd7, 8'd6, 1'b0, 16'h002A, 3, 1, "post_rst7x6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_mult_lp.md
Name: seq_mult_lp

Overview:
- Parametrised, iterative shift-add multiplier for the low-power datapath. Successor to the fixed 8-bit multiplier.
- Adds a valid/ready handshake on input and output, and a per-transaction signed/unsigned mode.
- Saves power through early termination, accumulator update gated on multiplier bit, and operand/product registers that load only on handshake.
- Sits between operand producers and accumulation logic; one transaction in flight at a time.

Parameters:
- WIDTH, 8: operand width W; product is 2W bits.
- EARLY_TERM, 1: 1 = finish as soon as the remaining multiplier bits are zero; 0 = always run W iterations (fixed latency).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept; high iff state IDLE
- a  in  W  multiplicand
- b  in  W  multiplier
- signed_mode  in  1  1 = a and b are two's complement; sampled with operands
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  2W  result, registered
- busy  out  1  high in CALC or DONE

Behaviour:
- Reset (async, rst=1): state IDLE, product=0, out_valid=0, busy=0, all internal registers cleared. in_ready=1 while in IDLE, including during reset.
- Reset mid-operation: the transaction is discarded with no output. The block is in IDLE immediately.

States:
- IDLE:
  - Accept occurs when in_valid && in_ready.
  - On accept, latch mcand=|a|, mplr=|b| (magnitudes when signed_mode=1, raw values otherwise).
  - Latch neg = signed_mode & (a[W-1]^b[W-1]). Set acc=0, count=0. Go to CALC.
  - in_valid outside IDLE is ignored; no overlap with a pending transaction.
- CALC, one iteration per cycle:
  - If mplr[0]=1, acc += mcand. The acc register is enabled only when mplr[0]=1.
  - Then mcand <<= 1, mplr >>= 1, count++.
  - Exit after the iteration where count==W-1, or (EARLY_TERM=1 and next mplr==0).
  - On exit: product <= neg ? -(acc_next) : acc_next, truncated to 2W bits. Go to DONE.
- DONE:
  - out_valid=1; product stable.
  - On out_ready=1, go to IDLE and drop out_valid.
  - product keeps its value until the next result load; it does not toggle to 0.

Latency and arithmetic:
- out_valid rises N+1 cycles after the accept edge.
- N = W when EARLY_TERM=0.
- N = (index of highest set bit of |b|) + 1 when EARLY_TERM=1; minimum N=1, including b=0.
- The magnitude of the most-negative value (e.g. -128 for W=8) is 2^(W-1) and fits in W unsigned bits. mcand shift register is 2W bits. The signed result always fits in 2W bits.
- Unsigned mode ignores neg. Full 2W-bit result; no saturation.
- Back-to-back: after an output handshake, the next accept is possible on the following cycle (IDLE for ≥1 cycle).

Decomposition:
- Shared package lp_mult_pkg: state enum (IDLE, CALC, DONE) and default WIDTH constant.
- One natural sub-module: mult_sign_mag.
  - Combinational abs/negate helper, parametrised width.
  - Used at operand accept (|x|) and at result (conditional two's-complement negate).
- FSM and datapath stay in seq_mult_lp.

Test Plan (WIDTH=8, EARLY_TERM=1 unless stated):
1. Unsigned a=13, b=11 -> product 0x008F; N=4, out_valid 5 cycles after accept.
2. Signed a=0xFD (-3), b=0x05 -> product 0xFFF1 (-15); N=3.
3. Signed a=0x80, b=0x80 (-128*-128) -> product 0x4000; N=8. Unsigned a=0xFF, b=0xFF -> 0xFE01.
4. Unsigned b=0, a=0xA5 -> product 0x0000 after N=1. Same operands with EARLY_TERM=0 -> N=8 and same result.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid=1, product stable, in_ready=0. A second in_valid pulse (a=2, b=2) during this time is not accepted. Release out_ready -> IDLE next cycle.
6. Assert rst during CALC (after 2 iterations of 0xFF*0xFF) -> product=0, out_valid=0, in_ready=1 immediately. A new transaction 7*6 afterwards yields 0x002A.
